// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Multi-read-port register file with byte-strobed writes,
//               write-to-read bypass and a pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wen,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
  output logic [NUM_RD-1:0]              rbusy,
  input  logic                           iss_valid,
  input  logic [ADDR_WIDTH-1:0]          iss_addr,
  output logic [ADDR_WIDTH:0]            pend_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_ok, iss_ok;
  logic [DATA_WIDTH-1:0] wr_word;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  assign wr_ok   = wen && !((ZERO_REG != 0) && (waddr == '0));
  assign iss_ok  = iss_valid && !((ZERO_REG != 0) && (iss_addr == '0));
  assign wr_word = merge_bytes(regs_q[waddr], wdata, wstrb);

  // Issue is applied after the clear so a new producer wins over writeback.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[waddr]    = 1'b0;
    if (iss_ok) pend_d[iss_addr] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + (ADDR_WIDTH+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) regs_q[waddr] <= wr_word;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic                  is_zero;
      logic                  hit;
      logic [DATA_WIDTH-1:0] stored;

      assign ra      = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign is_zero = (ZERO_REG != 0) && (ra == '0);
      assign stored  = regs_q[ra];
      // Bypass is suppressed while reset is held so reads stay at zero.
      assign hit     = wr_ok && !rst && (waddr == ra);

      assign rdata[k*DATA_WIDTH +: DATA_WIDTH] =
        is_zero ? '0 : (hit ? merge_bytes(stored, wdata, wstrb) : stored);
      assign rbusy[k] = !is_zero && pend_q[ra] && !(wen && (waddr == ra));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Self-checking bench for reg_file_mp (4 read ports).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NV = 28;

  logic            clk = 1'b0;
  logic            rst;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [DW/8-1:0] wstrb;
  logic [DW-1:0]   wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]   rbusy;
  logic            iss_valid;
  logic [AW-1:0]   iss_addr;
  logic [AW:0]     pend_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  reg_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wstrb(wstrb),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [3:0]      wstrb;
    logic [DW-1:0]   wdata;
    logic            iss;
    logic [AW-1:0]   iaddr;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] erd;
    logic [NR-1:0]   ebusy;
    logic [AW:0]     ecnt;
  } vec_t;

  vec_t tv [NV];

  function automatic vec_t mk(
    input logic [31:0] we, wa, ws, wd, iv, ia,
    input logic [31:0] r0, r1, r2, r3,
    input logic [31:0] e0, e1, e2, e3,
    input logic [31:0] eb, ec
  );
    vec_t v;
    v.wen   = we[0];
    v.waddr = wa[AW-1:0];
    v.wstrb = ws[3:0];
    v.wdata = wd;
    v.iss   = iv[0];
    v.iaddr = ia[AW-1:0];
    v.ra    = {r3[AW-1:0], r2[AW-1:0], r1[AW-1:0], r0[AW-1:0]};
    v.erd   = {e3, e2, e1, e0};
    v.ebusy = eb[NR-1:0];
    v.ecnt  = ec[AW:0];
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input vec_t v);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rdata%0d", k), idx, rdata[k*DW +: DW], v.erd[k*DW +: DW]);
    end
    chk("rbusy", idx, 32'(rbusy), 32'(v.ebusy));
    chk("pend_cnt", idx, 32'(pend_cnt), 32'(v.ecnt));
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wstrb = '0; wdata = '0;
    raddr = '0; iss_valid = 1'b0; iss_addr = '0;

    //          wen wa strb  wdata         iss ia  ra0..ra3      exp rdata0..3                                     busy  cnt
    tv[0]  = mk(0, 0, 4'h0, 0,            0, 0,  0, 1, 2, 3,   0, 0, 0, 0,                                        4'h0, 0);
    tv[1]  = mk(1, 3, 4'hF, 32'h11223344, 0, 0,  3, 0, 0, 0,   32'h11223344, 0, 0, 0,                             4'h0, 0);
    tv[2]  = mk(1, 3, 4'h5, 32'hAABBCCDD, 0, 0,  3, 0, 0, 0,   32'h11BB33DD, 0, 0, 0,                             4'h0, 0);
    tv[3]  = mk(0, 0, 4'h0, 0,            0, 0,  3, 0, 0, 0,   32'h11BB33DD, 0, 0, 0,                             4'h0, 0);
    tv[4]  = mk(1, 0, 4'hF, 32'hFFFFFFFF, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0,                                        4'h0, 0);
    tv[5]  = mk(0, 0, 4'h0, 0,            0, 0,  0, 0, 0, 0,   0, 0, 0, 0,                                        4'h0, 0);
    tv[6]  = mk(0, 0, 4'h0, 0,            1, 7,  7, 0, 0, 0,   0, 0, 0, 0,                                        4'h0, 0);
    tv[7]  = mk(0, 0, 4'h0, 0,            0, 0,  7, 7, 0, 3,   0, 0, 0, 32'h11BB33DD,                             4'h3, 1);
    tv[8]  = mk(1, 7, 4'hF, 32'h5,        0, 0,  7, 0, 0, 0,   32'h5, 0, 0, 0,                                    4'h0, 1);
    tv[9]  = mk(0, 0, 4'h0, 0,            0, 0,  7, 0, 0, 0,   32'h5, 0, 0, 0,                                    4'h0, 0);
    tv[10] = mk(0, 0, 4'h0, 0,            1, 9,  9, 0, 0, 0,   0, 0, 0, 0,                                        4'h0, 0);
    tv[11] = mk(1, 9, 4'hF, 32'hCAFEF00D, 1, 9,  9, 0, 0, 0,   32'hCAFEF00D, 0, 0, 0,                             4'h0, 1);
    tv[12] = mk(0, 0, 4'h0, 0,            0, 0,  9, 0, 0, 0,   32'hCAFEF00D, 0, 0, 0,                             4'h1, 1);
    tv[13] = mk(0, 0, 4'h0, 0,            1, 9,  9, 0, 0, 0,   32'hCAFEF00D, 0, 0, 0,                             4'h1, 1);
    tv[14] = mk(0, 0, 4'h0, 0,            0, 0,  9, 0, 0, 0,   32'hCAFEF00D, 0, 0, 0,                             4'h1, 1);
    tv[15] = mk(1, 9, 4'h0, 0,            0, 0,  9, 0, 0, 0,   32'hCAFEF00D, 0, 0, 0,                             4'h0, 1);
    tv[16] = mk(0, 0, 4'h0, 0,            0, 0,  9, 0, 0, 0,   32'hCAFEF00D, 0, 0, 0,                             4'h0, 0);
    tv[17] = mk(1, 1, 4'hF, 1,            0, 0,  0, 0, 0, 0,   0, 0, 0, 0,                                        4'h0, 0);
    tv[18] = mk(1, 2, 4'hF, 2,            0, 0,  0, 0, 0, 0,   0, 0, 0, 0,                                        4'h0, 0);
    tv[19] = mk(1, 3, 4'hF, 3,            0, 0,  0, 0, 0, 0,   0, 0, 0, 0,                                        4'h0, 0);
    tv[20] = mk(1, 4, 4'hF, 4,            0, 0,  0, 0, 0, 0,   0, 0, 0, 0,                                        4'h0, 0);
    tv[21] = mk(1, 2, 4'hF, 32'h99,       0, 0,  1, 2, 3, 4,   1, 32'h99, 3, 4,                                   4'h0, 0);
    tv[22] = mk(0, 0, 4'h0, 0,            0, 0,  1, 2, 3, 4,   1, 32'h99, 3, 4,                                   4'h0, 0);
    tv[23] = mk(0, 0, 4'h0, 0,            1, 1,  1, 2, 0, 0,   1, 32'h99, 0, 0,                                   4'h0, 0);
    tv[24] = mk(0, 0, 4'h0, 0,            1, 2,  1, 2, 0, 0,   1, 32'h99, 0, 0,                                   4'h1, 1);
    tv[25] = mk(0, 0, 4'h0, 0,            0, 0,  1, 2, 0, 0,   1, 32'h99, 0, 0,                                   4'h3, 2);
    tv[26] = mk(1, 1, 4'h2, 32'h0000AB00, 0, 0,  1, 2, 0, 0,   32'h0000AB01, 32'h99, 0, 0,                        4'h2, 2);
    tv[27] = mk(0, 0, 4'h0, 0,            0, 0,  1, 2, 0, 0,   32'h0000AB01, 32'h99, 0, 0,                        4'h2, 1);

    // Reset state while held.
    #2;
    chk("rst_rdata0", 0, rdata[0 +: DW], 32'h0);
    chk("rst_cnt", 0, 32'(pend_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      wen = tv[i].wen; waddr = tv[i].waddr; wstrb = tv[i].wstrb; wdata = tv[i].wdata;
      iss_valid = tv[i].iss; iss_addr = tv[i].iaddr; raddr = tv[i].ra;
      #2;
      chk_outputs(i, tv[i]);
      @(posedge clk);
      #1;
    end

    // Mid-cycle asynchronous reset with r2 pending and r5 freshly written.
    wen = 1'b1; waddr = 5; wstrb = 4'hF; wdata = 32'hDEADBEEF; iss_valid = 1'b0;
    raddr = {5'd0, 5'd6, 5'd2, 5'd5};
    @(posedge clk);
    #1 wen = 1'b0;
    #1;
    chk("pre_rst_r5", 0, rdata[0 +: DW], 32'hDEADBEEF);
    chk("pre_rst_busy", 0, 32'(rbusy), 32'h2);
    chk("pre_rst_cnt", 0, 32'(pend_cnt), 32'h1);
    rst = 1'b1;
    wen = 1'b1; waddr = 5; wdata = 32'h00000001; iss_valid = 1'b1; iss_addr = 6;
    #1;
    chk("rst_r5", 1, rdata[0 +: DW], 32'h0);
    chk("rst_r2", 1, rdata[DW +: DW], 32'h0);
    chk("rst_busy", 1, 32'(rbusy), 32'h0);
    chk("rst_cnt", 1, 32'(pend_cnt), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_r5", 2, rdata[0 +: DW], 32'h0);
    chk("rst_hold_cnt", 2, 32'(pend_cnt), 32'h0);
    #1 rst = 1'b0; wdata = 32'h00000077;
    #1;
    chk("post_rst_byp", 3, rdata[0 +: DW], 32'h77);
    @(posedge clk);
    #1 wen = 1'b0; iss_valid = 1'b0;
    #1;
    chk("post_rst_r5", 4, rdata[0 +: DW], 32'h77);
    chk("post_rst_cnt", 4, 32'(pend_cnt), 32'h1);
    chk("post_rst_busy", 4, 32'(rbusy), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
